fence_unit: RTL and testbench

Memory-ordering unit that answers the fence capture from PC/next-PC control. It consumes the fence strobe and the captured `predecessor`/`successor` PCs, and counts data-memory requests that are still outstanding. On a fence it stalls the pipeline until all memory traffic has drained, then issues a one-cycle redirect to the successor PC. It sits between decode/PC control and the data-memory port.

---
 rtl/fence_unit.sv | 167 ++++++++++++++++
 tb/tb_fence_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fence_unit.sv
// fence_unit: memory-ordering fence. Tracks in-flight data-memory requests,
// stalls fetch on a fence until traffic drains, then pulses a redirect to the
// successor PC.
// Optional feature: define FENCE_TIMEOUT_EN to bound the drain wait to
// TIMEOUT_CYCLES cycles; without it the drain waits indefinitely and
// timeout_err is tied to 0.
module fence_unit #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int TIMEOUT_CYCLES  = 1024,
    localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic          clk,
    input  logic          reset,        // asynchronous, active-low
    input  logic          fence,
    input  logic [31:0]   predecessor,
    input  logic [31:0]   successor,
    input  logic          mem_issue,
    input  logic          mem_resp,
    output logic          stall,
    output logic          redirect,
    output logic [31:0]   redirect_pc,
    output logic [31:0]   fence_pc,
    output logic [CW-1:0] outstanding,
    output logic          count_err,
    output logic          timeout_err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRAIN  = 2'd1,
        RESUME = 2'd2
    } state_t;

    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);

    state_t        state_q, state_d;
    logic          fence_q, fence_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   fence_pc_q, fence_pc_d;
    logic [31:0]   redirect_pc_q, redirect_pc_d;
    logic          count_err_q, count_err_d;

    logic [CW-1:0] cnt_next;
    logic          cnt_fault;
    logic          fence_start;

`ifdef FENCE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_err_q, timeout_err_d;
    logic          tmo_hit;
`else
    logic          unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // Gated by reset so stall reads 0 while reset is held, even with fence high.
    assign fence_start = reset & fence & ~fence_q & (state_q == IDLE);

    // Saturating in-flight counter; faults flag overflow and underflow.
    always_comb begin
        cnt_next  = cnt_q;
        cnt_fault = 1'b0;
        unique case ({mem_issue, mem_resp})
            2'b10: begin
                if (cnt_q == CNT_MAX) cnt_fault = 1'b1;
                else                  cnt_next  = cnt_q + 1'b1;
            end
            2'b01: begin
                if (cnt_q == '0) cnt_fault = 1'b1;
                else             cnt_next  = cnt_q - 1'b1;
            end
            default: cnt_next = cnt_q;
        endcase
    end

`ifdef FENCE_TIMEOUT_EN
    // Drain-cycle counter: zero outside DRAIN, so it restarts on every entry.
    always_comb begin
        tmo_d   = (state_q == DRAIN) ? tmo_q + 1'b1 : '0;
        tmo_hit = (state_q == DRAIN) && (tmo_q == TMO_LAST) && (cnt_next != '0);
    end
`endif

    // Next-state logic, PC capture and sticky error accumulation.
    always_comb begin
        state_d       = state_q;
        fence_d       = fence;
        cnt_d         = cnt_next;
        fence_pc_d    = fence_pc_q;
        redirect_pc_d = redirect_pc_q;
        count_err_d   = count_err_q | cnt_fault;
`ifdef FENCE_TIMEOUT_EN
        timeout_err_d = timeout_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (fence_start) begin
                    fence_pc_d    = predecessor;
                    redirect_pc_d = successor;
                    state_d       = DRAIN;
                end
            end
            DRAIN: begin
                if (cnt_next == '0) begin
                    state_d = RESUME;
                end
`ifdef FENCE_TIMEOUT_EN
                else if (tmo_hit) begin
                    // Give up on the lost responses and resync the counter.
                    state_d       = RESUME;
                    timeout_err_d = 1'b1;
                    cnt_d         = '0;
                end
`endif
            end
            RESUME: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State registers; everything clears asynchronously on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            fence_q       <= 1'b0;
            cnt_q         <= '0;
            fence_pc_q    <= '0;
            redirect_pc_q <= '0;
            count_err_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            fence_q       <= fence_d;
            cnt_q         <= cnt_d;
            fence_pc_q    <= fence_pc_d;
            redirect_pc_q <= redirect_pc_d;
            count_err_q   <= count_err_d;
        end
    end

`ifdef FENCE_TIMEOUT_EN
    // Timeout counter and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign stall       = fence_start | (state_q != IDLE);
    assign redirect    = (state_q == RESUME);
    assign redirect_pc = redirect_pc_q;
    assign fence_pc    = fence_pc_q;
    assign outstanding = cnt_q;
    assign count_err   = count_err_q;

endmodule

// File: tb/tb_fence_unit.sv
// Testbench for fence_unit: directed scenarios plus a randomized run checked
// against a transaction-level reference model.
module tb_fence_unit;

    localparam int MAXO = 8;
    localparam int TMO  = 16;
    localparam int CW   = $clog2(MAXO + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          fence = 1'b0;
    logic [31:0]   predecessor = '0;
    logic [31:0]   successor = '0;
    logic          mem_issue = 1'b0;
    logic          mem_resp = 1'b0;
    logic          stall;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic [31:0]   fence_pc;
    logic [CW-1:0] outstanding;
    logic          count_err;
    logic          timeout_err;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state
    int          m_cnt;
    bit          m_cerr, m_terr, m_busy, m_pend, m_fprev;
    int          m_drain;
    logic [31:0] m_fpc, m_rpc;
    bit          e_stall, e_redir;

    fence_unit #(.MAX_OUTSTANDING(MAXO), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset(reset), .fence(fence),
        .predecessor(predecessor), .successor(successor),
        .mem_issue(mem_issue), .mem_resp(mem_resp),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .fence_pc(fence_pc), .outstanding(outstanding),
        .count_err(count_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_cnt = 0; m_cerr = 0; m_terr = 0; m_busy = 0; m_pend = 0;
        m_fprev = 0; m_drain = 0; m_fpc = '0; m_rpc = '0;
    endtask

    // Expected combinational outputs for the current inputs.
    task automatic model_expect();
        e_stall = m_busy || (fence && !m_fprev);
        e_redir = m_pend;
    endtask

    // Advance the model by one clock: fence in progress until drained, then
    // one redirect cycle, then free again.
    task automatic model_advance();
        int n;
        bit start;
        n = m_cnt + int'(mem_issue) - int'(mem_resp);
        start = fence && !m_fprev && !m_busy;
        if (n > MAXO) begin n = MAXO; m_cerr = 1; end
        if (n < 0)    begin n = 0;    m_cerr = 1; end
        if (m_pend) begin
            m_pend = 0; m_busy = 0;
        end else if (start) begin
            m_busy = 1; m_drain = 0; m_fpc = predecessor; m_rpc = successor;
        end else if (m_busy) begin
            m_drain++;
            if (n == 0) m_pend = 1;
`ifdef FENCE_TIMEOUT_EN
            else if (m_drain == TMO) begin m_pend = 1; m_terr = 1; n = 0; end
`endif
        end
        m_cnt = n;
        m_fprev = fence;
    endtask

    // Drive inputs just after a rising edge and let them settle.
    task automatic step(input bit f, input bit i, input bit r,
                        input logic [31:0] p, input logic [31:0] s);
        fence = f; mem_issue = i; mem_resp = r; predecessor = p; successor = s;
        #2;
        model_expect();
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_advance();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; fence = 0; mem_issue = 0; mem_resp = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_cmp += 7;
        if (stall !== 1'b0)       begin n_bad++; $display("FAIL rst_stall got %b want 0", stall); end
        if (redirect !== 1'b0)    begin n_bad++; $display("FAIL rst_redirect got %b want 0", redirect); end
        if (redirect_pc !== 32'h0) begin n_bad++; $display("FAIL rst_redirect_pc got %h want 0", redirect_pc); end
        if (fence_pc !== 32'h0)   begin n_bad++; $display("FAIL rst_fence_pc got %h want 0", fence_pc); end
        if (outstanding !== '0)   begin n_bad++; $display("FAIL rst_outstanding got %0d want 0", outstanding); end
        if (count_err !== 1'b0)   begin n_bad++; $display("FAIL rst_count_err got %b want 0", count_err); end
        if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL rst_timeout_err got %b want 0", timeout_err); end
        reset = 1'b1;
        // Get mid-fence with traffic in flight, then reset without a clock.
        repeat (3) begin step(0, 1, 0, '0, '0); tick(); end
        step(1, 0, 0, 32'h200, 32'h204);
        n_cmp++;
        if (stall !== 1'b1) begin n_bad++; $display("FAIL mid_stall_pre got %b want 1", stall); end
        tick();
        step(1, 0, 0, '0, '0);
        reset = 1'b0;
        #1;
        n_cmp += 5;
        if (stall !== 1'b0)      begin n_bad++; $display("FAIL async_stall got %b want 0", stall); end
        if (redirect !== 1'b0)   begin n_bad++; $display("FAIL async_redirect got %b want 0", redirect); end
        if (outstanding !== '0)  begin n_bad++; $display("FAIL async_outstanding got %0d want 0", outstanding); end
        if (fence_pc !== 32'h0)  begin n_bad++; $display("FAIL async_fence_pc got %h want 0", fence_pc); end
        if (redirect_pc !== 32'h0) begin n_bad++; $display("FAIL async_redirect_pc got %h want 0", redirect_pc); end
        fence = 0;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 0, 0, '0, '0);
        n_cmp += 2;
        if (stall !== 1'b0)     begin n_bad++; $display("FAIL post_rst_stall got %b want 0", stall); end
        if (outstanding !== '0) begin n_bad++; $display("FAIL post_rst_outstanding got %0d want 0", outstanding); end
        tick();
    endtask

    task automatic test_idle_fence();
        step(0, 0, 0, '0, '0); tick();
        for (int j = 0; j < 5; j++) begin
            if (j == 0) step(1, 0, 0, 32'h100, 32'h104);
            else        step(j < 4, 0, 0, $urandom, $urandom);
            n_cmp += 2;
            if (stall !== (j <= 2))
                begin n_bad++; $display("FAIL idle_stall T+%0d got %b want %b", j, stall, (j <= 2)); end
            if (redirect !== (j == 2))
                begin n_bad++; $display("FAIL idle_redirect T+%0d got %b want %b", j, redirect, (j == 2)); end
            if (j == 2) begin
                n_cmp++;
                if (redirect_pc !== 32'h104)
                    begin n_bad++; $display("FAIL idle_redirect_pc got %h want 104", redirect_pc); end
            end
            if (j >= 1) begin
                n_cmp++;
                if (fence_pc !== 32'h100)
                    begin n_bad++; $display("FAIL idle_fence_pc T+%0d got %h want 100", j, fence_pc); end
            end
            tick();
        end
    endtask

    task automatic test_drain();
        int exp_out [8] = '{3, 3, 3, 2, 2, 1, 0, 0};
        logic [31:0] succ;
        succ = $urandom;
        repeat (3) begin step(0, 1, 0, '0, '0); tick(); end
        for (int j = 0; j < 8; j++) begin
            step(1, 0, (j == 2 || j == 4 || j == 5), (j == 0) ? 32'h300 : 32'h0,
                 (j == 0) ? succ : 32'h0);
            n_cmp += 3;
            if (outstanding !== CW'(exp_out[j]))
                begin n_bad++; $display("FAIL drain_outstanding T+%0d got %0d want %0d", j, outstanding, exp_out[j]); end
            if (redirect !== (j == 6))
                begin n_bad++; $display("FAIL drain_redirect T+%0d got %b want %b", j, redirect, (j == 6)); end
            if (stall !== (j <= 6))
                begin n_bad++; $display("FAIL drain_stall T+%0d got %b want %b", j, stall, (j <= 6)); end
            if (j == 6) begin
                n_cmp++;
                if (redirect_pc !== succ)
                    begin n_bad++; $display("FAIL drain_redirect_pc got %h want %h", redirect_pc, succ); end
            end
            tick();
        end
        step(0, 0, 0, '0, '0); tick();
    endtask

    task automatic test_counter();
        do_reset();
        for (int k = 0; k < 9; k++) begin
            step(0, 1, 0, '0, '0);
            if (k == 8) begin
                n_cmp += 2;
                if (outstanding !== CW'(8)) begin n_bad++; $display("FAIL cnt_full got %0d want 8", outstanding); end
                if (count_err !== 1'b0)     begin n_bad++; $display("FAIL cnt_full_err got %b want 0", count_err); end
            end
            tick();
        end
        step(0, 1, 1, '0, '0);
        n_cmp += 2;
        if (outstanding !== CW'(8)) begin n_bad++; $display("FAIL cnt_sat got %0d want 8", outstanding); end
        if (count_err !== 1'b1)     begin n_bad++; $display("FAIL cnt_ovf_err got %b want 1", count_err); end
        tick();
        step(0, 0, 0, '0, '0);
        n_cmp++;
        if (outstanding !== CW'(8)) begin n_bad++; $display("FAIL cnt_both_at_max got %0d want 8", outstanding); end
        tick();
        do_reset();
        repeat (3) begin step(0, 1, 0, '0, '0); tick(); end
        step(0, 1, 1, '0, '0); tick();
        step(0, 0, 0, '0, '0);
        n_cmp += 2;
        if (outstanding !== CW'(3)) begin n_bad++; $display("FAIL cnt_both got %0d want 3", outstanding); end
        if (count_err !== 1'b0)     begin n_bad++; $display("FAIL cnt_both_err got %b want 0", count_err); end
        tick();
        do_reset();
        step(0, 0, 1, '0, '0); tick();
        step(0, 0, 0, '0, '0);
        n_cmp += 2;
        if (outstanding !== '0) begin n_bad++; $display("FAIL cnt_udf got %0d want 0", outstanding); end
        if (count_err !== 1'b1) begin n_bad++; $display("FAIL cnt_udf_err got %b want 1", count_err); end
        tick();
    endtask

    task automatic test_held_fence();
        int pulses1, pulses2, stalls;
        pulses1 = 0; pulses2 = 0; stalls = 0;
        do_reset();
        step(0, 0, 0, '0, '0); tick();
        for (int j = 0; j < 10; j++) begin
            step(1, 0, 0, 32'h400, 32'h404);
            pulses1 += int'(redirect);
            stalls  += int'(stall);
            tick();
        end
        step(0, 0, 0, '0, '0); tick();
        for (int j = 0; j < 6; j++) begin
            step(1, 0, 0, 32'h500, 32'h504);
            pulses2 += int'(redirect);
            tick();
        end
        n_cmp += 4;
        if (pulses1 != 1) begin n_bad++; $display("FAIL held_pulses got %0d want 1", pulses1); end
        if (stalls != 3)  begin n_bad++; $display("FAIL held_stall_cycles got %0d want 3", stalls); end
        if (pulses2 != 1) begin n_bad++; $display("FAIL refence_pulses got %0d want 1", pulses2); end
        if (redirect_pc !== 32'h504) begin n_bad++; $display("FAIL refence_pc got %h want 504", redirect_pc); end
        step(0, 0, 0, '0, '0); tick();
    endtask

    task automatic test_drain_bound();
        do_reset();
        step(0, 1, 0, '0, '0); tick();
`ifdef FENCE_TIMEOUT_EN
        for (int j = 0; j < 20; j++) begin
            step(j < 3, 0, 0, 32'h600, 32'h604);
            n_cmp++;
            if (redirect !== (j == 17))
                begin n_bad++; $display("FAIL tmo_redirect T+%0d got %b want %b", j, redirect, (j == 17)); end
            if (j == 16) begin
                n_cmp += 2;
                if (timeout_err !== 1'b0)   begin n_bad++; $display("FAIL tmo_early_err got %b want 0", timeout_err); end
                if (outstanding !== CW'(1)) begin n_bad++; $display("FAIL tmo_early_cnt got %0d want 1", outstanding); end
            end
            if (j == 17) begin
                n_cmp += 2;
                if (timeout_err !== 1'b1) begin n_bad++; $display("FAIL tmo_err got %b want 1", timeout_err); end
                if (outstanding !== '0)   begin n_bad++; $display("FAIL tmo_cnt got %0d want 0", outstanding); end
            end
            tick();
        end
`else
        begin
            int pulses;
            pulses = 0;
            for (int j = 0; j < 40; j++) begin
                step(j < 3, 0, 0, 32'h600, 32'h604);
                pulses += int'(redirect);
                tick();
            end
            step(0, 0, 0, '0, '0);
            n_cmp += 3;
            if (pulses != 0)          begin n_bad++; $display("FAIL wait_pulses got %0d want 0", pulses); end
            if (stall !== 1'b1)       begin n_bad++; $display("FAIL wait_stall got %b want 1", stall); end
            if (timeout_err !== 1'b0) begin n_bad++; $display("FAIL wait_tmo_err got %b want 0", timeout_err); end
            tick();
            for (int j = 0; j < 4; j++) begin
                step(0, 0, (j == 0), '0, '0);
                n_cmp++;
                if (redirect !== (j == 1))
                    begin n_bad++; $display("FAIL wait_release_redirect +%0d got %b want %b", j, redirect, (j == 1)); end
                tick();
            end
        end
`endif
    endtask

    task automatic test_random();
        int shown;
        bit f, i, r;
        shown = 0;
        do_reset();
        f = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) f = ~f;
            i = ($urandom_range(0, 99) < ((c % 600) < 300 ? 45 : 25));
            r = ($urandom_range(0, 99) < ((c % 600) < 300 ? 25 : 45));
            step(f, i, r, $urandom, $urandom);
            n_cmp++;
            if (stall !== e_stall || redirect !== e_redir || outstanding !== CW'(m_cnt) ||
                redirect_pc !== m_rpc || fence_pc !== m_fpc || count_err !== m_cerr ||
                timeout_err !== m_terr) begin
                n_bad++;
                if (shown < 20) begin
                    shown++;
                    $display("FAIL random cyc %0d got st=%b rd=%b out=%0d rpc=%h fpc=%h ce=%b te=%b want st=%b rd=%b out=%0d rpc=%h fpc=%h ce=%b te=%b",
                             c, stall, redirect, outstanding, redirect_pc, fence_pc, count_err, timeout_err,
                             e_stall, e_redir, m_cnt, m_rpc, m_fpc, m_cerr, m_terr);
                end
            end
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle_fence();
        test_drain();
        test_counter();
        test_held_fence();
        test_drain_bound();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
